// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and the receiver FSM state type.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: consumer-side bus of the buffered UART receiver.
// Handshake: 'data_ready' says 'out' holds the FIFO head byte; a cycle with
// rd=1 and data_ready=1 pops that byte on the rising edge, while rd=1 with
// data_ready=0 is ignored. Error pulses are single-cycle, no handshake.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          rd;
  logic [7:0]    out;
  logic          data_ready;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;
  rx_state_t     state;       // receiver FSM state, for observation only

  modport master (
    input  rd,
    output out, data_ready, count, frame_err, overrun, parity_err, state
  );

  modport slave (
    output rd,
    input  out, data_ready, count, frame_err, overrun, parity_err, state
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO. The head word is always on
// dout_o (zero while empty); a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver feeding a show-ahead FIFO.
// Default frame is 8N1. Defining UART_RX_PARITY_EN switches to 8E1 with a
// live parity_err pulse; otherwise parity_err is tied low.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           buffer,
  uart_rx_fifo_if.master bus
);

  localparam logic [3:0] TC_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] TC_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BI_LAST = 3'(DATA_BITS - 1);

  logic                 s1_q;
  logic                 s_q;
  rx_state_t            state_q;
  logic [3:0]           tc_q;
  logic [2:0]           bi_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 stop_tick;
  logic                 push_req;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s_q  <= 1'b1;
    end else begin
      s1_q <= buffer;
      s_q  <= s1_q;
    end
  end

  // Stop-bit sample instant; a good byte is written on this very edge.
  assign stop_tick = (state_q == STOP) && tick && (tc_q == TC_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic parity_err_q;
  assign push_req       = stop_tick && s_q && !par_bad_q;
  assign bus.parity_err = parity_err_q;
`else
  assign push_req       = stop_tick && s_q;
  assign bus.parity_err = 1'b0;
`endif

  // Deframing FSM with registered error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tc_q         <= '0;
      bi_q         <= '0;
      sh_q         <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!s_q) begin
            state_q <= START;
            tc_q    <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tc_q == TC_MID) begin
              tc_q <= '0;
              if (s_q) begin
                state_q <= IDLE;      // too short to be a start bit
              end else begin
                state_q <= DATA;
                bi_q    <= '0;
              end
            end else begin
              tc_q <= tc_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tc_q <= tc_q + 1'b1;
            if (tc_q == TC_LAST) begin
              sh_q <= {s_q, sh_q[DATA_BITS-1:1]};
              bi_q <= bi_q + 1'b1;
              if (bi_q == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tc_q <= tc_q + 1'b1;
            if (tc_q == TC_LAST) begin
              // Even parity: data bits plus parity bit hold an even count of ones.
              par_bad_q    <= ^{sh_q, s_q};
              parity_err_q <= ^{sh_q, s_q};
              state_q      <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            tc_q <= tc_q + 1'b1;
            if (tc_q == TC_LAST) begin
              if (s_q) begin
                overrun_q <= push_req && fifo_full && !bus.rd;
                state_q   <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          if (s_q) state_q <= IDLE;   // one frame_err per held-low line
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (bus.rd),
    .din_i   (sh_q),
    .dout_o  (bus.out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (bus.count)
  );

  assign bus.data_ready = !fifo_empty;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: serial frames driven onto the line, expected bytes and
// error counts kept by a queue-based model, a monitor checking every pop.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic tick   = 1'b0;
  logic buffer = 1'b1;
  int   tcnt   = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
    tick = (tcnt == 0);
  end

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .buffer (buffer),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int fe_exp = 0, ov_exp = 0, pe_exp = 0;
  int fe_seen = 0, ov_seen = 0, pe_seen = 0;
  int n_checks = 0, n_fail = 0;
  logic abort = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  // Reference: what the receiver does with one complete frame.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit,
                             input logic flip_par);
    if (!stop_bit) fe_exp++;
    else if (flip_par) pe_exp++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else ov_exp++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    buffer = b;
    for (int i = 0; i < BIT_CLKS; i++) begin
      if (abort) begin
        buffer = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic flip_par);
    logic [10:0] bits;
    int nb;
    bits = '0;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, (^d) ^ flip_par, d, 1'b0};
    nb   = 11;
`else
    bits = {1'b0, stop_bit, d, 1'b0};
    nb   = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      drive_bit(bits[i]);
      if (abort) return;
    end
    model_frame(d, stop_bit, flip_par);
  endtask

  task automatic idle(input int clks);
    buffer = 1'b1;
    repeat (clks) begin @(posedge clk); #1; end
  endtask

  task automatic read_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; bus.rd = 1'b1;
      @(posedge clk); #1; bus.rd = 1'b0;
    end
  endtask

  task automatic read_burst(input int n);
    if (n > 0) begin
      @(posedge clk); #1; bus.rd = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
      bus.rd = 1'b0;
    end
  endtask

  task automatic checkpoint(input string tag);
    int hd;
    @(negedge clk);
    check({tag, "_count"}, int'(bus.count), exp_q.size());
    check({tag, "_ready"}, int'(bus.data_ready), int'(exp_q.size() != 0));
    check({tag, "_frame_err"}, fe_seen, fe_exp);
    check({tag, "_overrun"}, ov_seen, ov_exp);
    check({tag, "_parity_err"}, pe_seen, pe_exp);
    if (exp_q.size() != 0) begin
      hd = int'(exp_q[0]);
      check({tag, "_head"}, int'(bus.out), hd);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_err)  fe_seen++;
      if (bus.overrun)    ov_seen++;
      if (bus.parity_err) pe_seen++;
      if (bus.rd && bus.data_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", exp_q.size(), 1);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("pop_data", int'(bus.out), int'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.rd = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_count", int'(bus.count), 0);
    check("rst_ready", int'(bus.data_ready), 0);
    check("rst_out", int'(bus.out), 0);
    check("rst_pulses", int'({bus.frame_err, bus.overrun, bus.parity_err}), 0);
    check("rst_state", int'(bus.state), int'(IDLE));
    @(posedge clk); #1; reset = 1'b0;
    idle(2 * BIT_CLKS);

    // Single byte, no reads.
    send_frame(8'h9D, 1'b1, 1'b0);
    idle(BIT_CLKS);
    checkpoint("single");
    read_pulses(1);
    checkpoint("single_drained");

    // Back-to-back frames, read one at a time.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(BIT_CLKS);
    checkpoint("b2b");
    read_pulses(3);
    checkpoint("b2b_drained");

    // Short low glitch: no start.
    buffer = 1'b0;
    repeat (5 * TICK_DIV) begin @(posedge clk); #1; end
    idle(2 * BIT_CLKS);
    checkpoint("glitch");
    check("glitch_state", int'(bus.state), int'(IDLE));

    // Framing error, then held low, then a good byte.
    send_frame(8'h55, 1'b0, 1'b0);
    buffer = 1'b0;
    repeat (30 * BIT_CLKS) begin @(posedge clk); #1; end
    idle(2 * BIT_CLKS);
    checkpoint("break");
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(BIT_CLKS);
    checkpoint("after_break");
    read_burst(1);

    // Overrun: five bytes into four entries, then sustained drain.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    idle(BIT_CLKS);
    checkpoint("overrun");
    read_burst(4);
    checkpoint("overrun_drained");

    // Reset mid-frame with two bytes queued.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    checkpoint("pre_reset");
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        repeat (4 * BIT_CLKS) begin @(posedge clk); #1; end
        buffer = 1'b1;
        abort  = 1'b1;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("reset_count", int'(bus.count), 0);
        check("reset_ready", int'(bus.data_ready), 0);
      end
    join
    abort = 1'b0;
    idle(24 * BIT_CLKS);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(BIT_CLKS);
    checkpoint("after_reset");
    read_burst(1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b1);
    idle(BIT_CLKS);
    checkpoint("parity_bad");
    send_frame(8'h01, 1'b1, 1'b0);
    idle(BIT_CLKS);
    checkpoint("parity_good");
    read_burst(1);
`endif

    // Randomized bursts with random partial drains.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      idle(BIT_CLKS);
      checkpoint("rand_fill");
      read_burst($urandom_range(0, exp_q.size()));
      checkpoint("rand_drain");
    end

    read_burst(exp_q.size() + 1);
    checkpoint("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receiver: oversamples the serial `buffer` line on the 16x `tick` from `baud_generator`, deframes 8N1 characters LSB-first, and pushes each good byte into a show-ahead FIFO. It sits at the far end of the line driven by `tx`. It lets a consumer drain bytes with a read strobe instead of catching single-cycle pulses. It also reports framing errors, overruns and, optionally, parity errors.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock; the only reset.
- `tick`  in  1  single-cycle enable at 16x baud rate, from `baud_generator`. With `limit=650` at a 100 MHz clock this is 9600 baud.
- `buffer`  in  1  asynchronous serial line; idles high.
- `rd`  in  1  pop strobe; ignored when `data_ready`=0.
- `out`  out  8  FIFO head byte; valid while `data_ready`=1.
- `data_ready`  out  1  FIFO not empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped because FIFO full.
- `parity_err`  out  1  one-cycle pulse; tied 0 unless `UART_RX_PARITY_EN`.

## Operation
- `buffer` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `s`.
- A 4-bit tick counter `tc` advances only on `tick`. A 3-bit bit index `bi` counts data bits.
- **IDLE:** when `s`=0, go to START with `tc`=0.
- **START:** on the tick where `tc`=7 (mid start bit):
  - if `s`=1, this is a glitch; return to IDLE.
  - otherwise clear `tc` and go to DATA with `bi`=0.
- **DATA:** on the tick where `tc`=15, shift `s` into the shift register MSB (LSB-first framing) and increment `bi`. After `bi`=7, go to PARITY if enabled, else STOP.
- **PARITY** (macro only): on `tc`=15, sample the parity bit, then go to STOP.
- **STOP:** on `tc`=15, sample the stop bit.
  - `s`=1: the byte is good. Push it, or pulse `overrun` if the FIFO is full. Go to IDLE.
  - `s`=0: pulse `frame_err`, discard the byte, go to BREAK.
- **BREAK:** wait for `s`=1, then go to IDLE. A held-low line yields exactly one `frame_err`.
- A parity-error byte is discarded with a `parity_err` pulse; it is not pushed.
- FIFO behaviour:
  - Push and pop in the same cycle: both take effect and `count` is unchanged.
  - When full with `rd`=1, the push is accepted.
  - When empty, a push makes `out` valid the next cycle.
- Reset values: FSM in IDLE, `tc`=`bi`=0, FIFO empty, `count`=0, `data_ready`=0, `out`=0, all pulses 0.
- Reset mid-frame abandons the frame and flushes the FIFO. The remainder of that frame's bits may then be seen as a new start.

## Timing
- The byte is written on the clock edge of the stop-bit sample tick. `data_ready` rises on the following cycle.
- Latency from the line's falling start edge to `data_ready`: about 2 + (7 + 16·9)·T_tick clocks for 8N1, or 16 more ticks with parity.
- The stop sample is at 151 ticks after the start edge. IDLE is re-entered within the stop bit, so back-to-back frames with one stop bit are received without loss.
- `rd`: `out` and `count` update on the next edge. Sustained `rd`=1 drains one byte per clock.
- Error and overrun pulses are exactly one `clk` wide, registered, and aligned with the STOP/PARITY sample cycle.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: frame is 8E1. An even-parity bit follows the data. The PARITY state exists and `parity_err` is live.
- Undefined: frame is 8N1. The PARITY state is not compiled and `parity_err` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `DATA_BITS`=8, `OVERSAMPLE`=16, `MID_SAMPLE`=7.
- One sub-module, `uart_sync_fifo` (parameters `WIDTH`, `DEPTH`): show-ahead, with push/pop/full/empty/count. All framing logic stays in `uart_rx_fifo`.

## Test plan
- `tx` sends 157 (0x9D) through the `baud_generator` with `limit=650`; no `rd` -> `out`=0x9D, `data_ready`=1, `count`=1, no error pulses.
- Send 0x00, 0xFF, 0xA5 back-to-back, then pulse `rd` three times -> `out` shows 0x00, 0xFF, 0xA5 in order, `data_ready` falls after the third read.
- Drive a 5-tick low glitch on `buffer` -> returns to IDLE, no push, no pulses.
- Send a frame with the stop bit forced 0, then hold the line low for 3 frame times -> exactly one `frame_err` pulse, `count` stays 0, next valid byte 0x3C is received.
- With `DEPTH`=4, send 5 bytes 1..5 with no reads -> `count`=4, one `overrun` pulse, FIFO holds 1, 2, 3, 4.
- Assert `reset` mid-DATA with 2 bytes queued -> `count`=0 and `data_ready`=0 the next cycle; the next full frame 0x5A is received correctly. With `UART_RX_PARITY_EN`, a wrong-parity 0x01 gives a `parity_err` pulse and no push.
